rd_ps_burst_ctrl: RTL and testbench
===================================

Name: rd_ps_burst_ctrl

Overview:
Parametrised PS-DDR read controller. On each frame request it reads one frame from a ring of NUM_BUF frame buffers in PS DDR. The frame is split into bursts of at most BURST_WORDS, and the returned beats are buffered in an internal FIFO. Data leaves on a valid/ready stream toward PL processing, and the buffer index advances round-robin after every frame.

Parameters:
DATA_W, 32, DDR read data width in bits (multiple of 8)
ADDR_W, 32, byte address width
LEN_W, 24, frame word-count width
NUM_BUF, 3, frame buffers in the ring
BUF_STRIDE, 32'h0080_0000, byte offset between consecutive buffers
BURST_WORDS, 256, maximum words per DDR read burst
FIFO_DEPTH, 512, FIFO entries (power of two, >= BURST_WORDS)

Ports:
ps_clk  in  1  single clock for the whole block
ps_rst  in  1  synchronous reset, active-high
cfg_base_addr  in  ADDR_W  byte address of buffer 0, sampled at frame_req
cfg_frame_words  in  LEN_W  words per frame, sampled at frame_req
frame_req  in  1  start-frame pulse; honoured only in IDLE
frame_busy  out  1  high from accepted frame_req until frame_done
frame_done  out  1  one-cycle pulse when a frame completes
buf_idx  out  clog2(NUM_BUF)  buffer currently or next to be read
ps_ddr_rd_start  out  1  one-cycle burst start pulse
ps_ddr_rd_addr  out  ADDR_W  burst byte address
ps_ddr_rd_length  out  32  burst length in bytes
ps_ddr_rd_finish  in  1  burst complete pulse
ps_ddr_rd_en  in  1  read data beat valid; cannot be back-pressured
ps_ddr_rd_data  in  DATA_W  read data beat
m_data  out  DATA_W  output stream data
m_valid  out  1  output stream valid
m_ready  in  1  output stream ready
err_flags  out  3  sticky errors: [0] FIFO overflow, [1] length mismatch, [2] unexpected beat

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE, buf_idx=0, FIFO is flushed.
  - Reset asserted mid-burst abandons the burst immediately and returns to IDLE.
- States: IDLE, CHECK, ISSUE, WAIT, NEXT, DONE.
- IDLE:
  - frame_req=1 latches cfg_*, computes addr = cfg_base_addr + buf_idx*BUF_STRIDE and remain = cfg_frame_words, then goes to CHECK.
  - frame_req while busy is ignored.
- CHECK:
  - remain==0 goes to DONE; a zero-length frame issues no burst.
  - Otherwise blen = min(remain, BURST_WORDS).
  - Stay in CHECK until FIFO free slots >= blen, then go to ISSUE. This guarantees no overflow in a correct system.
- ISSUE:
  - ps_ddr_rd_start=1 for exactly this cycle.
  - ps_ddr_rd_addr = addr and ps_ddr_rd_length = blen*(DATA_W/8), both held stable until the next ISSUE.
  - Go to WAIT.
- WAIT:
  - Each ps_ddr_rd_en beat is pushed into the FIFO and increments beat_cnt.
  - On ps_ddr_rd_finish go to NEXT. A beat in the same cycle as finish is counted and pushed.
- NEXT:
  - If beat_cnt != blen, set err_flags[1].
  - remain -= blen, addr += blen*(DATA_W/8), clear beat_cnt, go to CHECK.
- DONE:
  - frame_done=1 for one cycle.
  - buf_idx wraps: NUM_BUF-1 goes to 0.
  - frame_busy drops in the same cycle; go to IDLE.
- Latency:
  - frame_req accepted in cycle N gives the first rd_start in cycle N+2 when the FIFO has room.
  - Between bursts, finish in cycle M gives the next rd_start in cycle M+3 at earliest.
- FIFO:
  - First-word-fall-through; m_valid = !empty; pop on m_valid & m_ready.
  - Simultaneous push and pop when full is allowed: count stays, no overflow.
  - Push when full and no pop drops the beat and sets err_flags[0].
- A ps_ddr_rd_en beat outside WAIT is dropped and sets err_flags[2].
- err_flags clear only on ps_rst.
- Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.

Optional Feature:
RD_PS_BYTE_SWAP_EN:
- When defined, each beat is byte-reversed before the FIFO push (PS little-endian to PL big-endian). This adds no latency.
- When undefined, data passes unchanged.

Decomposition:
- Package file rd_ps_pkg holds the state encoding localparams, the error-bit index constants and a clog2 function.
- One sub-module, rd_ps_sync_fifo: parametrised DATA_W/FIFO_DEPTH, FWFT, with full, empty and free-count outputs.

Test Plan:
- Single frame:
  - Stimulus: cfg_frame_words=600, BURST_WORDS=256, base 0x1000_0000, buf_idx=0.
  - Response: bursts at 0x1000_0000/1024B, 0x1000_0400/1024B, 0x1000_0800/352B.
  - Response: 600 words out in order; one frame_done; buf_idx=1.
- Ring wrap: four consecutive frames of 16 words. Buffer addresses are base, +0x80_0000, +0x100_0000, then base again; buf_idx sequence 1,2,0,1.
- Back-pressure:
  - m_ready=0 while a 300-word frame is read with FIFO_DEPTH=512.
  - Second burst (44 words) issues; third never requested; no err_flags[0].
  - Releasing m_ready drains all 300 words.
- Zero length and busy: cfg_frame_words=0 gives frame_done 2 cycles after frame_req, with no rd_start. A frame_req during a busy frame is ignored (one done only).
- Errors:
  - finish after 250 of 256 beats sets err_flags[1].
  - A beat while IDLE sets err_flags[2].
  - Both stay set until ps_rst.
- Reset mid-burst: ps_rst during WAIT gives all outputs 0 next cycle, FIFO empty and IDLE. Late beats then set err_flags[2].

Source files
------------

// File: rtl/rd_ps_pkg.sv
// rd_ps_pkg: shared definitions for the PS-DDR frame read controller.
//   - FSM state encoding (localparams plus an enum built from them)
//   - bit positions inside err_flags
//   - clog2 / idx_width helpers used to size ports and counters
package rd_ps_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CHECK = ST_CHECK,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_NEXT  = ST_NEXT,
    S_DONE  = ST_DONE
  } state_t;

  localparam int ERR_OVERFLOW = 0;  // beat arrived with the FIFO full
  localparam int ERR_LEN      = 1;  // burst returned a different beat count
  localparam int ERR_BEAT     = 2;  // beat arrived outside a burst

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width that stays legal (>= 1 bit) for a single-entry ring.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rd_ps_sync_fifo.sv
// rd_ps_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst       clock, synchronous active-high reset (flushes contents)
//   push/push_data write side; a push while full is taken only if a pop
//                  happens in the same cycle, otherwise it is discarded
//   pop/pop_data   read side; pop_data shows the head entry whenever !empty
//   full, empty    occupancy flags
//   free           number of unused entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module rd_ps_sync_fifo import rd_ps_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   free
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_V = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_V);
  assign free     = DEPTH_V - count;
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so push-while-full is legal then.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rd_ps_burst_ctrl.sv
// rd_ps_burst_ctrl: reads one frame per frame_req from a ring of NUM_BUF
// frame buffers in PS DDR, in bursts of at most BURST_WORDS, buffers the
// returned beats in a FWFT FIFO and streams them out on m_*.
//
// Ports:
//   ps_clk, ps_rst            clock, synchronous active-high reset
//   cfg_base_addr             byte address of buffer 0 (sampled on accept)
//   cfg_frame_words           words per frame (sampled on accept)
//   frame_req                 start pulse, only honoured while idle
//   frame_busy / frame_done   frame in progress / one-cycle completion pulse
//   buf_idx                   ring index being read or read next
//   ps_ddr_rd_start/addr/length  burst request (length in bytes)
//   ps_ddr_rd_finish          burst complete pulse
//   ps_ddr_rd_en/data         returned beats, cannot be stalled
//   m_data/m_valid/m_ready    output stream
//   err_flags                 sticky: [0] overflow, [1] length mismatch,
//                             [2] beat outside a burst
//
// Output stream handshake: m_valid/m_data are held while m_valid && !m_ready;
// a word transfers on every cycle with m_valid && m_ready. m_valid never
// depends on m_ready.
//
// Build option: define RD_PS_BYTE_SWAP_EN to byte-reverse every beat before
// it enters the FIFO (little-endian PS to big-endian PL); no added latency.
module rd_ps_burst_ctrl import rd_ps_pkg::*; #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          LEN_W       = 24,
  parameter int          NUM_BUF     = 3,
  parameter logic [31:0] BUF_STRIDE  = 32'h0080_0000,
  parameter int          BURST_WORDS = 256,
  parameter int          FIFO_DEPTH  = 512
) (
  input  logic                           ps_clk,
  input  logic                           ps_rst,
  input  logic [ADDR_W-1:0]              cfg_base_addr,
  input  logic [LEN_W-1:0]               cfg_frame_words,
  input  logic                           frame_req,
  output logic                           frame_busy,
  output logic                           frame_done,
  output logic [idx_width(NUM_BUF)-1:0]  buf_idx,
  output logic                           ps_ddr_rd_start,
  output logic [ADDR_W-1:0]              ps_ddr_rd_addr,
  output logic [31:0]                    ps_ddr_rd_length,
  input  logic                           ps_ddr_rd_finish,
  input  logic                           ps_ddr_rd_en,
  input  logic [DATA_W-1:0]              ps_ddr_rd_data,
  output logic [DATA_W-1:0]              m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [2:0]                     err_flags
);

  localparam int               IDX_W     = idx_width(NUM_BUF);
  localparam int               BYTES     = DATA_W / 8;
  localparam int               CNT_W     = clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]      BYTES_W   = 32'(BYTES);
  localparam logic [LEN_W-1:0] BURST_MAX = LEN_W'(BURST_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BUF - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remain;
  logic [LEN_W-1:0]  blen;
  logic [LEN_W-1:0]  blen_c;
  logic [LEN_W-1:0]  beat_cnt;
  logic              room_ok;

  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_free;
  logic              wait_beat;
  logic              stray_beat;
  logic              pop;

  assign blen_c     = (remain > BURST_MAX) ? BURST_MAX : remain;
  // Only issue a burst once the whole burst is guaranteed to fit.
  assign room_ok    = (32'(fifo_free) >= 32'(blen_c));
  assign wait_beat  = ps_ddr_rd_en && (state == S_WAIT);
  assign stray_beat = ps_ddr_rd_en && (state != S_WAIT);
  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_empty ? '0 : fifo_rdata;
  assign pop        = m_valid && m_ready;

`ifdef RD_PS_BYTE_SWAP_EN
  always_comb begin
    push_data = '0;
    for (int i = 0; i < BYTES; i++) begin
      push_data[8*i +: 8] = ps_ddr_rd_data[8*(BYTES-1-i) +: 8];
    end
  end
`else
  assign push_data = ps_ddr_rd_data;
`endif

  rd_ps_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ps_clk),
    .rst       (ps_rst),
    .push      (wait_beat),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  always_ff @(posedge ps_clk) begin
    if (ps_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    ps_ddr_rd_start = 1'b0;
    frame_done      = 1'b0;
    frame_busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_req) state_nx = S_CHECK;
      end
      S_CHECK: begin
        frame_busy = 1'b1;
        if (remain == '0)  state_nx = S_DONE;
        else if (room_ok)  state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        frame_busy      = 1'b1;
        ps_ddr_rd_start = 1'b1;
        state_nx        = S_WAIT;
      end
      S_WAIT: begin
        frame_busy = 1'b1;
        if (ps_ddr_rd_finish) state_nx = S_NEXT;
      end
      S_NEXT: begin
        frame_busy = 1'b1;
        state_nx   = S_CHECK;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ps_clk) begin
    if (ps_rst) begin
      addr             <= '0;
      remain           <= '0;
      blen             <= '0;
      beat_cnt         <= '0;
      buf_idx          <= '0;
      ps_ddr_rd_addr   <= '0;
      ps_ddr_rd_length <= '0;
      err_flags        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_req) begin
            addr   <= cfg_base_addr + ADDR_W'(32'(buf_idx) * BUF_STRIDE);
            remain <= cfg_frame_words;
          end
        end
        S_CHECK: begin
          // Burst outputs load on the way into ISSUE so they are valid
          // together with the start pulse and hold until the next burst.
          if (remain != '0 && room_ok) begin
            blen             <= blen_c;
            ps_ddr_rd_addr   <= addr;
            ps_ddr_rd_length <= 32'(blen_c) * BYTES_W;
          end
        end
        S_WAIT: begin
          if (ps_ddr_rd_en) beat_cnt <= beat_cnt + LEN_W'(1);
        end
        S_NEXT: begin
          if (beat_cnt != blen) err_flags[ERR_LEN] <= 1'b1;
          remain   <= remain - blen;
          addr     <= addr + ADDR_W'(32'(blen) * BYTES_W);
          beat_cnt <= '0;
        end
        S_DONE: begin
          buf_idx <= (buf_idx == LAST_IDX) ? '0 : buf_idx + IDX_W'(1);
        end
        default: ;
      endcase
      if (wait_beat && fifo_full && !pop) err_flags[ERR_OVERFLOW] <= 1'b1;
      if (stray_beat)                     err_flags[ERR_BEAT]     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_ps_burst_ctrl.sv
`timescale 1ns/1ps
module tb_rd_ps_burst_ctrl;

  localparam int          DATA_W      = 32;
  localparam int          ADDR_W      = 32;
  localparam int          LEN_W       = 24;
  localparam int          NUM_BUF     = 3;
  localparam logic [31:0] BUF_STRIDE  = 32'h0080_0000;
  localparam int          BURST_WORDS = 256;
  localparam int          FIFO_DEPTH  = 512;
  localparam int          BYTES       = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic ps_clk = 1'b0;
  logic ps_rst;
  always #5 ps_clk = ~ps_clk;

  int cyc = 0;
  always @(posedge ps_clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] cfg_base_addr;
  logic [LEN_W-1:0]  cfg_frame_words;
  logic              frame_req;
  logic              frame_busy;
  logic              frame_done;
  logic [1:0]        buf_idx;
  logic              ps_ddr_rd_start;
  logic [ADDR_W-1:0] ps_ddr_rd_addr;
  logic [31:0]       ps_ddr_rd_length;
  logic              ps_ddr_rd_finish;
  logic              ps_ddr_rd_en;
  logic [DATA_W-1:0] ps_ddr_rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [2:0]        err_flags;

  // DDR model beats and hand-injected stray beats share the data port.
  logic              ddr_en, ddr_fin, inj_en;
  logic [DATA_W-1:0] ddr_data, inj_data;
  assign ps_ddr_rd_en     = ddr_en | inj_en;
  assign ps_ddr_rd_data   = inj_en ? inj_data : ddr_data;
  assign ps_ddr_rd_finish = ddr_fin;

  rd_ps_burst_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .NUM_BUF(NUM_BUF),
    .BUF_STRIDE(BUF_STRIDE), .BURST_WORDS(BURST_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ps_clk(ps_clk), .ps_rst(ps_rst),
    .cfg_base_addr(cfg_base_addr), .cfg_frame_words(cfg_frame_words),
    .frame_req(frame_req), .frame_busy(frame_busy), .frame_done(frame_done),
    .buf_idx(buf_idx),
    .ps_ddr_rd_start(ps_ddr_rd_start), .ps_ddr_rd_addr(ps_ddr_rd_addr),
    .ps_ddr_rd_length(ps_ddr_rd_length), .ps_ddr_rd_finish(ps_ddr_rd_finish),
    .ps_ddr_rd_en(ps_ddr_rd_en), .ps_ddr_rd_data(ps_ddr_rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .err_flags(err_flags)
  );

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];        // expected output words, in order
  logic [63:0]       exp_burst_q[$];  // expected {addr, length_bytes}
  int   n_vec = 0;
  int   n_err = 0;
  int   model_idx = 0;
  int   done_exp = 0;
  int   done_cnt = 0;
  int   req_cyc = 0;
  int   last_fin_cyc = 0;
  bit   fin_valid = 0;
  bit   first_pending = 0;
  int   ddr_short = 0;
  bit   ddr_fast = 0;
  int   beats_sent = 0;
  int   ready_mode = 1;               // 0 stall, 1 always ready, 2 random
  logic [2:0] exp_err = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] d);
`ifdef RD_PS_BYTE_SWAP_EN
    logic [DATA_W-1:0] r;
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = d[8*(BYTES-1-i) +: 8];
    return r;
`else
    return d;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Accept a frame and derive its bursts from the frame rules directly.
  task automatic start_frame(input logic [31:0] base, input int words);
    logic [31:0] a;
    int rem, bl;
    @(posedge ps_clk); #1;
    cfg_base_addr   = base;
    cfg_frame_words = LEN_W'(words);
    frame_req       = 1'b1;
    req_cyc         = cyc;
    first_pending   = (words > 0);
    a   = base + 32'(model_idx) * BUF_STRIDE;
    rem = words;
    while (rem > 0) begin
      bl = (rem > BURST_WORDS) ? BURST_WORDS : rem;
      exp_burst_q.push_back({a, 32'(bl * BYTES)});
      a   = a + 32'(bl * BYTES);
      rem = rem - bl;
    end
    model_idx = (model_idx + 1) % NUM_BUF;
    done_exp++;
    @(posedge ps_clk); #1;
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt < done_exp && k < budget) begin
      @(negedge ps_clk);
      k++;
    end
    check("frame_done_count", 64'(done_cnt), 64'(done_exp));
    @(negedge ps_clk);
    check("buf_idx_after_frame", 64'(buf_idx), 64'(model_idx));
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge ps_clk);
      k++;
    end
    check("drain_complete", 64'(exp_q.size()), 64'(0));
    @(negedge ps_clk);
    check("fifo_empty_after_drain", 64'(m_valid), 64'(0));
  endtask

  task automatic run_frame(input logic [31:0] base, input int words);
    start_frame(base, words);
    wait_done(words * 20 + 200);
    wait_drain(words * 10 + 200);
  endtask

  task automatic inject_beat();
    @(posedge ps_clk); #1;
    inj_en   = 1'b1;
    inj_data = $urandom;
    @(posedge ps_clk); #1;
    inj_en   = 1'b0;
    @(negedge ps_clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, {frame_busy, frame_done, buf_idx, ps_ddr_rd_start, m_valid, err_flags}, '0);
    check({name, "_burst"}, {ps_ddr_rd_addr, ps_ddr_rd_length}, '0);
    check({name, "_data"}, 64'(m_data), '0);
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge ps_clk); #1;
    ps_rst = 1'b1;
    @(posedge ps_clk); #1;
    exp_q.delete();
    exp_burst_q.delete();
    model_idx = 0;
    exp_err   = '0;
    first_pending = 0;
    @(negedge ps_clk);
    check_reset_outputs("reset_state");
    repeat (cycles) @(posedge ps_clk);
    #1 ps_rst = 1'b0;
    done_exp = done_cnt;
  endtask

  // ---------------- stream ready driver ----------------
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge ps_clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- DDR read model ----------------
  initial begin
    int nb, sent;
    bit aborted;
    logic [63:0] eb;
    ddr_en = 1'b0; ddr_fin = 1'b0; ddr_data = '0;
    forever begin
      @(negedge ps_clk);
      if (!ps_rst && ps_ddr_rd_start) begin
        check("burst_expected", 64'(exp_burst_q.size() > 0), 64'(1));
        if (exp_burst_q.size() > 0) begin
          eb = exp_burst_q.pop_front();
          check("burst_addr", 64'(ps_ddr_rd_addr), 64'(eb[63:32]));
          check("burst_len", 64'(ps_ddr_rd_length), 64'(eb[31:0]));
        end
        if (first_pending) begin
          check("req_to_start_latency", 64'(cyc - req_cyc), 64'(2));
          first_pending = 0;
        end else if (fin_valid) begin
          check("finish_to_start_gap_ge3", 64'((cyc - last_fin_cyc) >= 3), 64'(1));
        end
        nb = int'(ps_ddr_rd_length / BYTES) - ddr_short;
        ddr_short = 0;
        sent = 0;
        aborted = 0;
        while (!aborted && sent < nb) begin
          @(posedge ps_clk); #2;
          if (ps_rst) aborted = 1;
          else if (ddr_fast || $urandom_range(0, 3) != 0) begin
            ddr_en   = 1'b1;
            ddr_data = $urandom;
            exp_q.push_back(swap_bytes(ddr_data));
            sent++;
            beats_sent++;
            ddr_fin  = (sent == nb) && ($urandom_range(0, 1) == 1);
          end else begin
            ddr_en = 1'b0;
          end
        end
        if (!aborted && !ddr_fin) begin
          @(posedge ps_clk); #2;
          if (ps_rst) aborted = 1;
          else begin
            ddr_en  = 1'b0;
            ddr_fin = 1'b1;
          end
        end
        if (!aborted) begin
          last_fin_cyc = cyc;
          fin_valid    = 1;
          @(posedge ps_clk); #2;
        end
        ddr_en  = 1'b0;
        ddr_fin = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge ps_clk) begin
    if (!ps_rst) begin
      if (frame_done) begin
        done_cnt++;
        check("busy_low_at_done", 64'(frame_busy), 64'(0));
      end
      if (m_valid && m_ready) begin
        check("output_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) check("m_data", 64'(m_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900_000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int b0, k, base;
    ps_rst = 1'b1;
    frame_req = 1'b0;
    cfg_base_addr = '0;
    cfg_frame_words = '0;
    inj_en = 1'b0;
    inj_data = '0;
    repeat (3) @(posedge ps_clk);
    @(negedge ps_clk);
    check_reset_outputs("power_on");
    @(posedge ps_clk); #1 ps_rst = 1'b0;

    // Single frame: 1024B, 1024B, 352B bursts, buf_idx -> 1.
    ready_mode = 1;
    run_frame(32'h1000_0000, 600);

    // Ring wrap: four small frames walk the buffer ring.
    for (int i = 0; i < 4; i++) run_frame(32'h1000_0000, 16);

    // Zero length: done exactly two cycles after the request, no burst.
    @(posedge ps_clk); #1;
    cfg_base_addr = 32'h2000_0000;
    cfg_frame_words = '0;
    frame_req = 1'b1;
    model_idx = (model_idx + 1) % NUM_BUF;
    done_exp++;
    @(negedge ps_clk);
    check("zero_done_cycle0", 64'(frame_done), 64'(0));
    @(posedge ps_clk); #1 frame_req = 1'b0;
    @(negedge ps_clk);
    check("zero_done_cycle1", 64'(frame_done), 64'(0));
    @(negedge ps_clk);
    check("zero_done_cycle2", 64'(frame_done), 64'(1));
    @(negedge ps_clk);
    check("zero_buf_idx", 64'(buf_idx), 64'(model_idx));

    // Busy: a second request mid-frame is ignored.
    start_frame(32'h3000_0000, 64);
    repeat (5) @(posedge ps_clk);
    #1 cfg_frame_words = LEN_W'(999);
    frame_req = 1'b1;
    @(negedge ps_clk);
    check("busy_during_frame", 64'(frame_busy), 64'(1));
    @(posedge ps_clk); #1 frame_req = 1'b0;
    wait_done(2000);
    repeat (30) @(negedge ps_clk);
    check("single_done_when_busy", 64'(done_cnt), 64'(done_exp));
    wait_drain(1000);

    // Back-pressure: 300 words fit in the FIFO with the stream stalled.
    ready_mode = 0;
    ddr_fast = 1;
    start_frame(32'h4000_0000, 300);
    wait_done(2000);
    check("bp300_no_overflow", 64'(err_flags), 64'(exp_err));
    check("bp300_valid_held", 64'(m_valid), 64'(1));
    ready_mode = 1;
    wait_drain(2000);

    // Back-pressure: 600 words fill the FIFO; third burst must wait.
    ready_mode = 0;
    start_frame(32'h4000_0000, 600);
    repeat (800) @(negedge ps_clk);
    check("bp600_third_held", 64'(exp_burst_q.size()), 64'(1));
    check("bp600_still_busy", 64'(frame_busy), 64'(1));
    check("bp600_no_overflow", 64'(err_flags), 64'(exp_err));
    ready_mode = 1;
    wait_done(3000);
    wait_drain(2000);
    ddr_fast = 0;

    // Errors: short burst, then a stray beat while idle; both sticky.
    ddr_short = 6;
    run_frame(32'h5000_0000, 256);
    exp_err[1] = 1'b1;
    check("err_len_mismatch", 64'(err_flags), 64'(exp_err));
    inject_beat();
    exp_err[2] = 1'b1;
    check("err_stray_beat", 64'(err_flags), 64'(exp_err));
    run_frame(32'h5000_0000, 16);
    check("err_sticky", 64'(err_flags), 64'(exp_err));

    // Reset mid-burst with data held in the FIFO.
    ready_mode = 0;
    b0 = beats_sent;
    start_frame(32'h6000_0000, 512);
    k = 0;
    while (beats_sent < b0 + 40 && k < 2000) begin
      @(negedge ps_clk);
      k++;
    end
    check("midburst_reached", 64'(beats_sent >= b0 + 40), 64'(1));
    apply_reset(1);
    ready_mode = 1;
    repeat (5) @(negedge ps_clk);
    check("idle_after_reset", 64'({frame_busy, m_valid}), 64'(0));
    inject_beat();
    exp_err[2] = 1'b1;
    check("late_beat_err", 64'(err_flags), 64'(exp_err));
    run_frame(32'h6000_0000, 16);

    // Randomised frames with random stream back-pressure.
    apply_reset(2);
    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      base = int'($urandom & 32'hFFFF_FFFC);
      run_frame(32'(base), $urandom_range(0, 700));
    end
    check("final_err_flags", 64'(err_flags), 64'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
